// File: rtl/string_led_sequencer_if.sv
// -----------------------------------------------------------------------------
// string_led_sequencer_if
// SRAM read port used by the LED string sequencer.
//   cs_n  : chip select, active low (driven by the sequencer)
//   addr  : byte address, ASIZE bits (driven by the sequencer)
//   rdata : read data, valid the cycle after cs_n=0 (driven by the SRAM)
// Modports: master = sequencer side, slave = SRAM side.
// -----------------------------------------------------------------------------
interface string_led_sequencer_if #(
   parameter int ASIZE = 32
) ();
   logic             cs_n;
   logic [ASIZE-1:0] addr;
   logic [7:0]       rdata;

   modport master (output cs_n, output addr, input rdata);
   modport slave  (input cs_n, input addr, output rdata);
endinterface

// File: rtl/string_led_sequencer.sv
// -----------------------------------------------------------------------------
// string_led_sequencer
// Reads pixel bytes over an SRAM read port and serialises them as a
// WS2812-style one-wire stream (bit1 = H H L, bit0 = H L L, MSB first,
// three prescaled ticks per bit), followed by a RST_TICKS low latch gap
// after every pass over the buffer.
//
// Ports
//   clk, reset      clock (rising edge), synchronous active-high reset
//   controller_en   0 aborts any transfer on the next edge
//   prescaler       tick period = prescaler+1 clocks (latched at start)
//   polarity        1 inverts led_out (applied live)
//   w_count         number of passes over the buffer (latched at start)
//   w_first/w_last  inclusive byte address range (latched at start)
//   start           start strobe, honoured only in IDLE
//   progress        1 while a transfer is active
//   sram            SRAM read port (master modport)
//   led_out         serial LED data
//
// Build option: STRING_LED_LOOP_EN -- when defined, w_count==0 starts an
// endless transfer that only ends on controller_en=0 or reset; otherwise
// a start with w_count==0 is ignored.
// -----------------------------------------------------------------------------
module string_led_sequencer #(
   parameter int ASIZE     = 32,
   parameter int PSIZE     = 32,
   parameter int RST_TICKS = 200
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      controller_en,
   input  logic [PSIZE-1:0]          prescaler,
   input  logic                      polarity,
   input  logic [3:0]                w_count,
   input  logic [ASIZE-1:0]          w_first,
   input  logic [ASIZE-1:0]          w_last,
   input  logic                      start,
   output logic                      progress,
   string_led_sequencer_if.master    sram,
   output logic                      led_out
);

   localparam int GW = $clog2(RST_TICKS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_SHIFT,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [PSIZE-1:0] presc_q, presc_d;
   logic [PSIZE-1:0] prescaler_q, prescaler_d;
   logic [ASIZE-1:0] first_q, first_d;
   logic [ASIZE-1:0] last_q, last_d;
   logic [3:0]       count_q, count_d;
   logic [3:0]       pass_q, pass_d;
   logic [1:0]       phase_q, phase_d;      // 0 = lead high, 1 = data, 2 = tail low
   logic [2:0]       bit_q, bit_d;          // bit index, 7 = MSB
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       next_byte_q, next_byte_d;
   logic             pref_q, pref_d;        // next byte already fetched for this byte
   logic             cap_q, cap_d;          // rdata of the prefetch is valid this cycle
   logic [GW-1:0]    gap_q, gap_d;
   logic [ASIZE-1:0] addr_q, addr_d;
   logic             cs_n_q, cs_n_d;
   logic             progress_q, progress_d;
   logic             led_out_q, led_out_d;

   logic             tick;
   logic             count_ok;
   logic             done;
   logic             raw_d;

`ifdef STRING_LED_LOOP_EN
   assign count_ok = 1'b1;
`else
   assign count_ok = (w_count != 4'd0);
`endif

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      prescaler_d = prescaler_q;
      first_d     = first_q;
      last_d      = last_q;
      count_d     = count_q;
      pass_d      = pass_q;
      phase_d     = phase_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      next_byte_d = next_byte_q;
      pref_d      = pref_q;
      cap_d       = 1'b0;
      gap_d       = gap_q;
      addr_d      = addr_q;
      cs_n_d      = 1'b1;
      progress_d  = progress_q;
      done        = 1'b0;
      tick        = (presc_q == prescaler_q);

      if (cap_q) begin
         next_byte_d = sram.rdata;
      end

      case (state_q)
         S_IDLE: begin
            if (start && controller_en && count_ok && (w_first <= w_last)) begin
               prescaler_d = prescaler;
               first_d     = w_first;
               last_d      = w_last;
               count_d     = w_count;
               pass_d      = 4'd0;
               addr_d      = w_first;
               cs_n_d      = 1'b0;
               progress_d  = 1'b1;
               state_d     = S_FETCH;
            end
         end

         S_FETCH: begin
            state_d = S_LOAD;
         end

         S_LOAD: begin
            shift_d = sram.rdata;
            presc_d = '0;
            phase_d = 2'd0;
            bit_d   = 3'd7;
            pref_d  = 1'b0;
            state_d = S_SHIFT;
         end

         S_SHIFT: begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            // A prefetch pulse was issued last cycle; its data arrives next cycle.
            cap_d   = !cs_n_q;
            if (tick) begin
               if ((phase_q == 2'd0) && (bit_q == 3'd7) && (addr_q != last_q)) begin
                  cs_n_d = 1'b0;
                  addr_d = addr_q + 1'b1;
                  pref_d = 1'b1;
               end
               if (phase_q == 2'd2) begin
                  phase_d = 2'd0;
                  if (bit_q == 3'd0) begin
                     if (pref_q) begin
                        shift_d = next_byte_q;
                        bit_d   = 3'd7;
                        pref_d  = 1'b0;
                        presc_d = '0;
                     end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                     end
                  end else begin
                     bit_d   = bit_q - 3'd1;
                     shift_d = {shift_q[6:0], 1'b0};
                  end
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end
         end

         S_GAP: begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
               if (gap_q == GW'(RST_TICKS - 1)) begin
                  pass_d = pass_q + 4'd1;
`ifdef STRING_LED_LOOP_EN
                  done = (count_q != 4'd0) && (pass_d == count_q);
`else
                  done = (pass_d == count_q);
`endif
                  if (done) begin
                     progress_d = 1'b0;
                     state_d    = S_IDLE;
                  end else begin
                     addr_d  = first_q;
                     cs_n_d  = 1'b0;
                     state_d = S_FETCH;
                  end
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort: return to IDLE with every counter cleared.
      if ((state_q != S_IDLE) && !controller_en) begin
         state_d    = S_IDLE;
         progress_d = 1'b0;
         cs_n_d     = 1'b1;
         cap_d      = 1'b0;
         presc_d    = '0;
         phase_d    = 2'd0;
         bit_d      = 3'd0;
         pass_d     = 4'd0;
         gap_d      = '0;
         pref_d     = 1'b0;
         addr_d     = '0;
      end

      // led_out is registered, so it is derived from the next-state values.
      raw_d     = (state_d == S_SHIFT) &&
                  ((phase_d == 2'd0) || ((phase_d == 2'd1) && shift_d[7]));
      led_out_d = raw_d ^ polarity;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         presc_q     <= '0;
         prescaler_q <= '0;
         first_q     <= '0;
         last_q      <= '0;
         count_q     <= 4'd0;
         pass_q      <= 4'd0;
         phase_q     <= 2'd0;
         bit_q       <= 3'd0;
         shift_q     <= 8'd0;
         next_byte_q <= 8'd0;
         pref_q      <= 1'b0;
         cap_q       <= 1'b0;
         gap_q       <= '0;
         addr_q      <= '0;
         cs_n_q      <= 1'b1;
         progress_q  <= 1'b0;
         led_out_q   <= polarity;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         prescaler_q <= prescaler_d;
         first_q     <= first_d;
         last_q      <= last_d;
         count_q     <= count_d;
         pass_q      <= pass_d;
         phase_q     <= phase_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         next_byte_q <= next_byte_d;
         pref_q      <= pref_d;
         cap_q       <= cap_d;
         gap_q       <= gap_d;
         addr_q      <= addr_d;
         cs_n_q      <= cs_n_d;
         progress_q  <= progress_d;
         led_out_q   <= led_out_d;
      end
   end

   assign progress  = progress_q;
   assign sram.cs_n = cs_n_q;
   assign sram.addr = addr_q;
   assign led_out   = led_out_q;

endmodule
